// File: rtl/mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_ctrl : multi-cycle MIPS control unit (IF/ID/EX/MEM/WB with mem stalls)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mc_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8,
  parameter int RET_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             ir_wr,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             shf_op,
  output logic             ext_op,
  output logic [4:0]       alu_op,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_code,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_e;

  localparam logic [5:0] OP_R = 6'h00, OP_ADDIU = 6'h09, OP_ORI = 6'h0D,
                         OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25,
                         FN_SLT = 6'h2A, FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03;
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR = 5'd3,
                         ALU_SLT = 5'd4, ALU_SLL = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7;
  localparam logic [1:0] TC_ILLEGAL = 2'd1, TC_TIMEOUT = 2'd2;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [TO_W-1:0]    wcnt_q, wcnt_d;
  logic [1:0]         trap_code_q, trap_code_d;
  logic [RET_W-1:0]   retired_q, retired_d;

  logic       is_r, legal, is_shift, dec_alu_src, dec_ext_op, wait_expired;
  logic [4:0] dec_alu_op;

  // Instruction decode; only meaningful once IR holds the instruction (ID onward).
  always_comb begin
    is_r        = (op == OP_R);
    legal       = 1'b1;
    is_shift    = 1'b0;
    dec_alu_op  = ALU_ADD;
    dec_alu_src = 1'b0;
    dec_ext_op  = 1'b1;
    case (op)
      OP_R: begin
        case (func)
          FN_ADDU: dec_alu_op = ALU_ADD;
          FN_SUBU: dec_alu_op = ALU_SUB;
          FN_AND:  dec_alu_op = ALU_AND;
          FN_OR:   dec_alu_op = ALU_OR;
          FN_SLT:  dec_alu_op = ALU_SLT;
          FN_SLL:  begin dec_alu_op = ALU_SLL; is_shift = 1'b1; end
          FN_SRL:  begin dec_alu_op = ALU_SRL; is_shift = 1'b1; end
          FN_SRA:  begin dec_alu_op = ALU_SRA; is_shift = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: dec_alu_src = 1'b1;
      OP_ORI: begin
        dec_alu_op  = ALU_OR;
        dec_alu_src = 1'b1;
        dec_ext_op  = 1'b0;
      end
      OP_BEQ:  dec_alu_op = ALU_SUB;
      OP_J:    ;
      default: legal = 1'b0;
    endcase
  end

  assign wait_expired = (TIMEOUT != 0) && (wcnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    wcnt_d      = '0;
    trap_code_d = trap_code_q;
    retired_d   = retired_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_wr     = 1'b0;
    pc_wr       = 1'b0;
    pc_src      = 2'd0;
    ir_wr       = 1'b0;
    reg_wr      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src     = 1'b0;
    shf_op      = 1'b0;
    ext_op      = 1'b0;
    alu_op      = ALU_ADD;
    case (state_q)
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_ID;
        end else if (wait_expired) begin
          state_d     = S_TRAP;
          trap_code_d = TC_TIMEOUT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_ID: begin
        if (!legal) begin
          state_d     = S_TRAP;
          trap_code_d = TC_ILLEGAL;
        end else if (op == OP_J) begin
          pc_wr     = 1'b1;
          pc_src    = 2'd2;
          retired_d = retired_q + 1'b1;
          state_d   = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        shf_op  = is_shift;
        ext_op  = dec_ext_op;
        if (op == OP_BEQ) begin
          pc_wr     = zero;
          pc_src    = 2'd1;
          retired_d = retired_q + 1'b1;
          state_d   = S_IF;
        end else if (op == OP_LW || op == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // ALU controls stay as in EX so the address path is stable for the whole access.
        alu_op   = dec_alu_op;
        alu_src  = dec_alu_src;
        ext_op   = dec_ext_op;
        dmem_req = 1'b1;
        dmem_wr  = (op == OP_SW);
        if (dmem_ready) begin
          if (op == OP_SW) begin
            retired_d = retired_q + 1'b1;
            state_d   = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d     = S_TRAP;
          trap_code_d = TC_TIMEOUT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = (op == OP_LW);
        retired_d  = retired_q + 1'b1;
        state_d    = S_IF;
      end
      S_TRAP: ;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IF;
      wcnt_q      <= '0;
      trap_code_q <= 2'd0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      trap_code_q <= trap_code_d;
      retired_q   <= retired_d;
    end
  end

  assign state     = state_q;
  assign trap      = (state_q == S_TRAP);
  assign trap_code = trap_code_q;
  assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mc_ctrl : scoreboard bench for mc_ctrl (TIMEOUT=16, RET_W=4)            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mc_ctrl;

  localparam int TIMEOUT = 16;
  localparam int RET_W   = 4;

  logic clk = 1'b0;
  logic rst, zero, imem_ready, dmem_ready;
  logic [5:0] op, func;
  logic imem_req, dmem_req, dmem_wr, pc_wr, ir_wr, reg_wr, reg_dst, mem_to_reg;
  logic alu_src, shf_op, ext_op, trap;
  logic [1:0] pc_src, trap_code;
  logic [4:0] alu_op;
  logic [2:0] state;
  logic [RET_W-1:0] retired;

  always #5 clk = ~clk;

  mc_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(8), .RET_W(RET_W)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_wr(dmem_wr), .pc_wr(pc_wr),
    .pc_src(pc_src), .ir_wr(ir_wr), .reg_wr(reg_wr), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .shf_op(shf_op), .ext_op(ext_op),
    .alu_op(alu_op), .state(state), .trap(trap), .trap_code(trap_code), .retired(retired)
  );

  typedef struct packed {
    logic [2:0] st;
    logic imem_req, dmem_req, dmem_wr, pc_wr;
    logic [1:0] pc_src;
    logic ir_wr, reg_wr, reg_dst, mem_to_reg, alu_src, shf_op, ext_op;
    logic [4:0] alu_op;
    logic trap;
    logic [1:0] trap_code;
    logic [RET_W-1:0] retired;
  } obs_t;

  obs_t obs;
  assign obs = '{st: state, imem_req: imem_req, dmem_req: dmem_req, dmem_wr: dmem_wr,
                 pc_wr: pc_wr, pc_src: pc_src, ir_wr: ir_wr, reg_wr: reg_wr,
                 reg_dst: reg_dst, mem_to_reg: mem_to_reg, alu_src: alu_src,
                 shf_op: shf_op, ext_op: ext_op, alu_op: alu_op, trap: trap,
                 trap_code: trap_code, retired: retired};

  localparam int C_R = 0, C_ADDIU = 1, C_ORI = 2, C_LW = 3, C_SW = 4, C_BEQ = 5,
                 C_J = 6, C_ILL = 7;

  obs_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [RET_W-1:0] ret_m;
  logic [1:0] tc_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cls(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      if (f inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h03}) return C_R;
      return C_ILL;
    end
    case (o)
      6'h09: return C_ADDIU;
      6'h0D: return C_ORI;
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04: return C_BEQ;
      6'h02: return C_J;
      default: return C_ILL;
    endcase
  endfunction

  function automatic obs_t base(input logic [2:0] s);
    obs_t e = '0;
    e.st = s;
    e.retired = ret_m;
    e.trap_code = tc_m;
    e.trap = (s == 3'd7);
    return e;
  endfunction

  // ALU-side controls expected in EX (and held into MEM for loads/stores).
  function automatic obs_t alu_ctl(input logic [2:0] s, input logic [5:0] o, input logic [5:0] f);
    obs_t e = base(s);
    int c = cls(o, f);
    case (c)
      C_R: case (f)
        6'h21: e.alu_op = 5'd0;
        6'h23: e.alu_op = 5'd1;
        6'h24: e.alu_op = 5'd2;
        6'h25: e.alu_op = 5'd3;
        6'h2A: e.alu_op = 5'd4;
        6'h00: e.alu_op = 5'd5;
        6'h02: e.alu_op = 5'd6;
        default: e.alu_op = 5'd7;
      endcase
      C_ORI: e.alu_op = 5'd3;
      C_BEQ: e.alu_op = 5'd1;
      default: e.alu_op = 5'd0;
    endcase
    e.alu_src = (c == C_ADDIU || c == C_ORI || c == C_LW || c == C_SW);
    e.shf_op  = (c == C_R) && (f == 6'h00 || f == 6'h02 || f == 6'h03) && (s == 3'd2);
    e.ext_op  = (c != C_ORI);
    return e;
  endfunction

  // Expected value is queued when the cycle's stimulus is applied, then popped
  // and compared once the DUT outputs have settled.
  task automatic step(input string tag, input obs_t e);
    obs_t x;
    exp_q.push_back(e);
    #2;
    x = exp_q.pop_front();
    check(tag, 64'(obs), 64'(x));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    ret_m = '0;
    tc_m = 2'd0;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int iw, input int dw);
    obs_t e;
    int c = cls(o, f);
    op = o; func = f; zero = z; dmem_ready = 1'b0;
    for (int k = 0; k <= iw; k++) begin
      imem_ready = (k == iw);
      e = base(3'd0);
      e.imem_req = 1'b1;
      if (k == iw) begin e.ir_wr = 1'b1; e.pc_wr = 1'b1; end
      step("IF", e);
    end
    imem_ready = 1'b0;
    e = base(3'd1);
    if (c == C_J) begin e.pc_wr = 1'b1; e.pc_src = 2'd2; end
    step("ID", e);
    if (c == C_J) begin ret_m++; return; end
    if (c == C_ILL) begin tc_m = 2'd1; return; end
    e = alu_ctl(3'd2, o, f);
    if (c == C_BEQ) begin e.pc_wr = z; e.pc_src = 2'd1; end
    step("EX", e);
    if (c == C_BEQ) begin ret_m++; return; end
    if (c == C_LW || c == C_SW) begin
      for (int k = 0; k <= dw; k++) begin
        dmem_ready = (k == dw);
        e = alu_ctl(3'd3, o, f);
        e.dmem_req = 1'b1;
        e.dmem_wr = (c == C_SW);
        step("MEM", e);
      end
      dmem_ready = 1'b0;
      if (c == C_SW) begin ret_m++; return; end
    end
    e = base(3'd4);
    e.reg_wr = 1'b1;
    e.reg_dst = (c == C_R);
    e.mem_to_reg = (c == C_LW);
    step("WB", e);
    ret_m++;
  endtask

  obs_t e0;

  initial begin
    rst = 1'b1; op = 6'h00; func = 6'h21; zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; ret_m = '0; tc_m = 2'd0;
    @(negedge clk);
    do_reset();

    e0 = base(3'd0); e0.imem_req = 1'b1;
    step("reset_state", e0);

    run_instr(6'h00, 6'h21, 1'b0, 0, 0);
    check("addu_retired", 64'(retired), 64'd1);
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);
    check("beq_retired", 64'(retired), 64'd4);
    foreach (e0.alu_op[i]) ;
    run_instr(6'h00, 6'h23, 1'b0, 1, 0);
    run_instr(6'h00, 6'h24, 1'b0, 0, 0);
    run_instr(6'h00, 6'h25, 1'b0, 0, 0);
    run_instr(6'h00, 6'h2A, 1'b0, 2, 0);
    run_instr(6'h00, 6'h00, 1'b0, 0, 0);
    run_instr(6'h00, 6'h02, 1'b0, 0, 0);
    run_instr(6'h00, 6'h03, 1'b0, 0, 0);
    run_instr(6'h09, 6'h11, 1'b0, 0, 0);
    run_instr(6'h0D, 6'h3F, 1'b0, 0, 0);
    run_instr(6'h2B, 6'h00, 1'b0, 0, 1);

    // Illegal opcode: sticky trap, no exit even with ready inputs high.
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int k = 0; k < 20; k++) step("trap_ill", base(3'd7));
    do_reset();
    e0 = base(3'd0); e0.imem_req = 1'b1;
    step("trap_reset", e0);

    // Illegal R-type function.
    do_reset();
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    step("trap_func", base(3'd7));

    // Instruction-fetch timeout after 16 waiting IF cycles.
    do_reset();
    op = 6'h00; func = 6'h21; imem_ready = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      e0 = base(3'd0); e0.imem_req = 1'b1;
      step("if_wait", e0);
    end
    tc_m = 2'd2;
    for (int k = 0; k < 3; k++) step("trap_to", base(3'd7));

    // Ready in the last allowed cycle wins over the timeout.
    do_reset();
    run_instr(6'h00, 6'h21, 1'b0, TIMEOUT - 1, 0);

    // Data-memory timeout.
    do_reset();
    run_instr(6'h23, 6'h00, 1'b0, 0, TIMEOUT - 1);
    do_reset();
    op = 6'h2B; func = 6'h00;
    imem_ready = 1'b1;
    e0 = base(3'd0); e0.imem_req = 1'b1; e0.ir_wr = 1'b1; e0.pc_wr = 1'b1;
    step("IF", e0);
    imem_ready = 1'b0;
    step("ID", base(3'd1));
    step("EX", alu_ctl(3'd2, 6'h2B, 6'h00));
    for (int k = 0; k < TIMEOUT; k++) begin
      e0 = alu_ctl(3'd3, 6'h2B, 6'h00); e0.dmem_req = 1'b1; e0.dmem_wr = 1'b1;
      step("mem_wait", e0);
    end
    tc_m = 2'd2;
    step("trap_dto", base(3'd7));

    // Retired counter wraps at 2^RET_W.
    do_reset();
    for (int k = 0; k < 17; k++) run_instr(6'h02, 6'h00, 1'b0, 0, 0);
    check("ret_wrap", 64'(retired), 64'd1);

    // Reset in the middle of a data-memory wait.
    run_instr(6'h00, 6'h21, 1'b0, 0, 0);
    op = 6'h23; func = 6'h00; imem_ready = 1'b1;
    e0 = base(3'd0); e0.imem_req = 1'b1; e0.ir_wr = 1'b1; e0.pc_wr = 1'b1;
    step("IF", e0);
    imem_ready = 1'b0;
    step("ID", base(3'd1));
    step("EX", alu_ctl(3'd2, 6'h23, 6'h00));
    for (int k = 0; k < 2; k++) begin
      e0 = alu_ctl(3'd3, 6'h23, 6'h00); e0.dmem_req = 1'b1;
      step("mem_wait", e0);
    end
    rst = 1'b1;
    e0 = alu_ctl(3'd3, 6'h23, 6'h00); e0.dmem_req = 1'b1;
    step("mem_rst", e0);
    rst = 1'b0;
    ret_m = '0; tc_m = 2'd0;
    e0 = base(3'd0); e0.imem_req = 1'b1;
    step("after_rst", e0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
